div_sequencer: RTL

Request/response front-end for the shift-subtract divider. It accepts operand pairs over a valid/ready request port and buffers them in a small FIFO. For each pair it drives the divider controller's START/READY handshake, captures quotient and remainder, and presents them on a valid/ready response port. Divide-by-zero requests bypass the divider and are answered locally.

---
 rtl/div_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// Valid/ready front-end for the shift-subtract divider: buffers operand pairs in a
// small FIFO, sequences the divider START/READY handshake and answers divide-by-zero locally.
module div_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_dividend,
  input  logic [WIDTH-1:0] req_divisor,
  output logic             div_start,
  input  logic             div_ready,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_quotient,
  output logic [WIDTH-1:0] rsp_remainder,
  output logic             rsp_divzero,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]      CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]      CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [AW-1:0]    PTR_ZERO = AW'(0);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PULSE     = 3'd1,
    S_WAIT_LOW  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t           state_r, state_nx_s;
  logic [WIDTH-1:0] fifo_dvd_r [DEPTH];
  logic [WIDTH-1:0] fifo_dvs_r [DEPTH];
  logic [AW-1:0]    wptr_r, rptr_r;
  logic [AW:0]      count_r, count_nx_s;
  logic             req_ready_r, busy_r, div_start_r, rsp_valid_r, rsp_divzero_r;
  logic [WIDTH-1:0] opnd_dvd_r, opnd_dvs_r, rsp_quot_r, rsp_rem_r;
  logic [WIDTH-1:0] head_dvd_s, head_dvs_s;
  logic             push_s, pop_s;

  assign push_s     = req_valid && req_ready_r;
  assign head_dvd_s = fifo_dvd_r[rptr_r];
  assign head_dvs_s = fifo_dvs_r[rptr_r];

  // Next FIFO occupancy from this cycle's push/pop pair
  always_comb begin
    count_nx_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nx_s = count_r + CNT_ONE;
      2'b01:   count_nx_s = count_r - CNT_ONE;
      default: count_nx_s = count_r;
    endcase
  end

  // Request FIFO storage, wrapping pointers, occupancy and registered req_ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_dvd_r[i] <= ZERO_W;
        fifo_dvs_r[i] <= ZERO_W;
      end
      wptr_r      <= PTR_ZERO;
      rptr_r      <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      req_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        fifo_dvd_r[wptr_r] <= req_dividend;
        fifo_dvs_r[wptr_r] <= req_divisor;
        wptr_r             <= wptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
      count_r     <= count_nx_s;
      req_ready_r <= (count_nx_s < CNT_FULL);
    end
  end

  // Sequencer next state and FIFO pop decision
  always_comb begin
    state_nx_s = state_r;
    pop_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (count_r != CNT_ZERO) begin
          pop_s = 1'b1;
          if (head_dvs_s != ZERO_W) begin
            state_nx_s = S_PULSE;
          end else begin
            state_nx_s = S_RESP;
          end
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_PULSE: state_nx_s = S_WAIT_LOW;
      // A low READY proves the divider has left its Idle state
      S_WAIT_LOW: begin
        if (!div_ready) begin
          state_nx_s = S_WAIT_DONE;
        end else begin
          state_nx_s = S_WAIT_LOW;
        end
      end
      S_WAIT_DONE: begin
        if (div_ready) begin
          state_nx_s = S_RESP;
        end else begin
          state_nx_s = S_WAIT_DONE;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_RESP;
        end
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State register, registered handshake outputs, operand and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= S_IDLE;
      div_start_r   <= 1'b0;
      rsp_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
      opnd_dvd_r    <= ZERO_W;
      opnd_dvs_r    <= ZERO_W;
      rsp_quot_r    <= ZERO_W;
      rsp_rem_r     <= ZERO_W;
      rsp_divzero_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      div_start_r <= (state_nx_s == S_PULSE);
      rsp_valid_r <= (state_nx_s == S_RESP);
      busy_r      <= (state_nx_s != S_IDLE) || (count_nx_s != CNT_ZERO);
      if (pop_s) begin
        opnd_dvd_r <= head_dvd_s;
        opnd_dvs_r <= head_dvs_s;
      end
      if (pop_s && (head_dvs_s == ZERO_W)) begin
        rsp_quot_r    <= ONES_W;
        rsp_rem_r     <= head_dvd_s;
        rsp_divzero_r <= 1'b1;
      end else if ((state_r == S_WAIT_DONE) && div_ready) begin
        rsp_quot_r    <= div_quotient;
        rsp_rem_r     <= div_remainder;
        rsp_divzero_r <= 1'b0;
      end
    end
  end

  assign req_ready     = req_ready_r;
  assign busy          = busy_r;
  assign div_start     = div_start_r;
  assign div_dividend  = opnd_dvd_r;
  assign div_divisor   = opnd_dvs_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_quotient  = rsp_quot_r;
  assign rsp_remainder = rsp_rem_r;
  assign rsp_divzero   = rsp_divzero_r;

endmodule
